// File: rtl/stopwatch_counter.sv
// ============================================================================
// Module      : stopwatch_counter
// Description : Prescaled timebase and MM:SS.hh BCD up/down counter with wrap
//               and expiry strobes. Optional lap-freeze display enabled by
//               defining STOPWATCH_LAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stopwatch_counter #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        running,
    input  logic        dir,
    input  logic        clear_pulse,
    input  logic        load,
    input  logic [7:0]  preset_min,
    input  logic [7:0]  preset_sec,
`ifdef STOPWATCH_LAP_EN
    input  logic        lap_btn,
`endif
    output logic [23:0] time_bcd,
    output logic [23:0] disp_bcd,
    output logic        tick,
    output logic        wrap,
    output logic        done,
    output logic        at_zero
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV >= 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] TERM = PW'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("stopwatch_counter: CLK_HZ/TICK_HZ must be at least 2");
    end

    logic [PW-1:0] presc;
    logic          term;

    logic [23:0]   up_next;
    logic [23:0]   dn_next;
    logic          up_wrap;
    logic          dn_done;
    logic [23:0]   load_value;

    logic          carry;
    logic          borrow;
    logic [3:0]    dig;
    logic [3:0]    dmax;

    assign term = running && (presc == TERM);

    // Clamp one preset digit to its legal maximum.
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] m);
        return (d > m) ? m : d;
    endfunction

    assign load_value = {clamp_digit(preset_min[7:4], 4'd5),
                         clamp_digit(preset_min[3:0], 4'd9),
                         clamp_digit(preset_sec[7:4], 4'd5),
                         clamp_digit(preset_sec[3:0], 4'd9),
                         8'h00};

    // Digit order from LSB: hun_o, hun_t, sec_o, sec_t, min_o, min_t.
    always_comb begin
        up_next = time_bcd;
        carry   = 1'b1;
        dig     = 4'd0;
        dmax    = 4'd9;
        for (int i = 0; i < 6; i++) begin
            dmax = (i == 3 || i == 5) ? 4'd5 : 4'd9;
            dig  = time_bcd[i*4 +: 4];
            if (carry) begin
                if (dig >= dmax) begin
                    up_next[i*4 +: 4] = 4'd0;
                end else begin
                    up_next[i*4 +: 4] = dig + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
        up_wrap = carry;
    end

    // Borrow chain; an all-zero count saturates instead of wrapping to 59:59.99.
    always_comb begin
        dn_next = time_bcd;
        borrow  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (time_bcd[i*4 +: 4] == 4'd0) begin
                    dn_next[i*4 +: 4] = (i == 3 || i == 5) ? 4'd5 : 4'd9;
                end else begin
                    dn_next[i*4 +: 4] = time_bcd[i*4 +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
        if (at_zero) begin
            dn_next = 24'h000000;
        end
        dn_done = (time_bcd == 24'h000001);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc    <= '0;
            time_bcd <= 24'h000000;
            tick     <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            done <= 1'b0;
            if (clear_pulse) begin
                presc    <= '0;
                time_bcd <= 24'h000000;
            end else if (load) begin
                presc    <= '0;
                time_bcd <= load_value;
            end else if (term) begin
                presc <= '0;
                tick  <= 1'b1;
                if (dir) begin
                    time_bcd <= up_next;
                    wrap     <= up_wrap;
                end else begin
                    time_bcd <= dn_next;
                    done     <= dn_done;
                end
            end else if (running) begin
                presc <= presc + PW'(1);
            end
        end
    end

    assign at_zero = (time_bcd == 24'h000000);

`ifdef STOPWATCH_LAP_EN
    logic        lap_hold;
    logic [23:0] lap_snap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_hold <= 1'b0;
            lap_snap <= 24'h000000;
        end else if (clear_pulse) begin
            lap_hold <= 1'b0;
        end else if (lap_btn) begin
            lap_hold <= ~lap_hold;
            if (!lap_hold) begin
                lap_snap <= time_bcd;
            end
        end
    end

    assign disp_bcd = lap_hold ? lap_snap : time_bcd;
`else
    assign disp_bcd = time_bcd;
`endif

endmodule

`default_nettype wire

// File: tb/tb_stopwatch_counter.sv
// ============================================================================
// Module      : tb_stopwatch_counter
// Description : Directed self-checking bench for stopwatch_counter (DIV=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        running;
    logic        dir;
    logic        clear_pulse;
    logic        load;
    logic [7:0]  preset_min;
    logic [7:0]  preset_sec;
`ifdef STOPWATCH_LAP_EN
    logic        lap_btn;
`endif
    logic [23:0] time_bcd;
    logic [23:0] disp_bcd;
    logic        tick;
    logic        wrap;
    logic        done;
    logic        at_zero;

    int total = 0;
    int bad   = 0;

    stopwatch_counter #(
        .CLK_HZ (10),
        .TICK_HZ(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .running    (running),
        .dir        (dir),
        .clear_pulse(clear_pulse),
        .load       (load),
        .preset_min (preset_min),
        .preset_sec (preset_sec),
`ifdef STOPWATCH_LAP_EN
        .lap_btn    (lap_btn),
`endif
        .time_bcd   (time_bcd),
        .disp_bcd   (disp_bcd),
        .tick       (tick),
        .wrap       (wrap),
        .done       (done),
        .at_zero    (at_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; running = 1'b0; dir = 1'b1; clear_pulse = 1'b0; load = 1'b0;
        preset_min = 8'h00; preset_sec = 8'h00;
`ifdef STOPWATCH_LAP_EN
        lap_btn = 1'b0;
`endif
        cyc(3);
        chk("rst_time", time_bcd, 24'h000000);
        chk("rst_disp", disp_bcd, 24'h000000);
        chk("rst_tick", tick, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_zero", at_zero, 1'b1);
        rst_n = 1'b1;

        // Scenario 1: free-running up count
        running = 1'b1; dir = 1'b1;
        cyc(9);
        chk("s1_no_tick9", tick, 1'b0);
        chk("s1_time9", time_bcd, 24'h000000);
        cyc(1);
        chk("s1_tick10", tick, 1'b1);
        chk("s1_time10", time_bcd, 24'h000001);
        cyc(1);
        chk("s1_tick_low", tick, 1'b0);
        cyc(9);
        chk("s1_tick20", tick, 1'b1);
        cyc(5);
        chk("s1_time25", time_bcd, 24'h000002);
        chk("s1_zero25", at_zero, 1'b0);

        // Scenario 2: wrap from 59:59.99
        preset_min = 8'h59; preset_sec = 8'h59; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("s2_load", time_bcd, 24'h595900);
        cyc(100);
        chk("s2_carry", time_bcd, 24'h595910);
        cyc(890);
        chk("s2_max", time_bcd, 24'h595999);
        chk("s2_no_wrap", wrap, 1'b0);
        cyc(10);
        chk("s2_wrapped", time_bcd, 24'h000000);
        chk("s2_wrap", wrap, 1'b1);
        chk("s2_zero", at_zero, 1'b1);
        cyc(1);
        chk("s2_wrap_low", wrap, 1'b0);

        // Scenario 3: down count from 00:01.00 to expiry and saturation
        dir = 1'b0; preset_min = 8'h00; preset_sec = 8'h01; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("s3_load", time_bcd, 24'h000100);
        cyc(10);
        chk("s3_borrow", time_bcd, 24'h000099);
        cyc(980);
        chk("s3_t99", time_bcd, 24'h000001);
        chk("s3_no_done", done, 1'b0);
        cyc(10);
        chk("s3_t100", time_bcd, 24'h000000);
        chk("s3_done", done, 1'b1);
        cyc(1);
        chk("s3_done_low", done, 1'b0);
        cyc(9);
        chk("s3_t101_tick", tick, 1'b1);
        chk("s3_t101_time", time_bcd, 24'h000000);
        chk("s3_t101_done", done, 1'b0);
        chk("s3_t101_wrap", wrap, 1'b0);

        // Scenario 4: preset sanitising while stopped
        running = 1'b0; preset_min = 8'hFF; preset_sec = 8'h7A; load = 1'b1;
        cyc(1);
        load = 1'b0;
        chk("s4_sanitise", time_bcd, 24'h595900);

        // Scenario 5: pause/resume, clear colliding with tick
        preset_min = 8'h00; preset_sec = 8'h01; load = 1'b1;
        cyc(1);
        load = 1'b0;
        dir = 1'b1; running = 1'b1;
        cyc(5);
        running = 1'b0;
        cyc(20);
        chk("s5_paused", time_bcd, 24'h000100);
        chk("s5_paused_tick", tick, 1'b0);
        running = 1'b1;
        cyc(4);
        chk("s5_before_tick", time_bcd, 24'h000100);
        clear_pulse = 1'b1;
        cyc(1);
        clear_pulse = 1'b0;
        chk("s5_clear_time", time_bcd, 24'h000000);
        chk("s5_clear_wrap", wrap, 1'b0);
        chk("s5_clear_done", done, 1'b0);
        cyc(3);
        running = 1'b0;
        cyc(7);
        running = 1'b1;
        cyc(6);
        chk("s5_resume_wait", time_bcd, 24'h000000);
        cyc(1);
        chk("s5_resume_time", time_bcd, 24'h000001);
        chk("s5_resume_tick", tick, 1'b1);
        dir = 1'b0;
        cyc(10);
        chk("s5_dir_time", time_bcd, 24'h000000);
        chk("s5_dir_done", done, 1'b1);

`ifdef STOPWATCH_LAP_EN
        // Scenario 6: lap freeze and release
        dir = 1'b1; clear_pulse = 1'b1;
        cyc(1);
        clear_pulse = 1'b0;
        cyc(30);
        chk("s6_time3", time_bcd, 24'h000003);
        lap_btn = 1'b1;
        cyc(1);
        lap_btn = 1'b0;
        chk("s6_capture", disp_bcd, 24'h000003);
        cyc(39);
        chk("s6_frozen", disp_bcd, 24'h000003);
        chk("s6_time7", time_bcd, 24'h000007);
        lap_btn = 1'b1;
        cyc(1);
        lap_btn = 1'b0;
        chk("s6_release", disp_bcd, 24'h000007);
`endif

        // Asynchronous reset mid-count
        dir = 1'b1; running = 1'b1;
        cyc(15);
        chk("rst2_pre", at_zero, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_time", time_bcd, 24'h000000);
        chk("rst2_zero", at_zero, 1'b1);
        chk("rst2_disp", disp_bcd, 24'h000000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
